// File: rtl/ibex_bloom_pkg.sv
// Shared opcodes, FSM states and hash constants for the Bloom-filter custom unit.
package ibex_bloom_pkg;

    typedef enum logic [4:0] {
        OP_INSERT = 5'd1,
        OP_CHECK  = 5'd2,
        OP_CLEAR  = 5'd3,
        OP_COUNT  = 5'd4
    } bloom_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HASH,
        ST_DONE
    } bloom_state_e;

    localparam logic [31:0] GOLDEN = 32'h9E3779B1;

    localparam logic [31:0] SALT [8] = '{
        32'h00000000, 32'h5BD1E995, 32'hCC9E2D51, 32'h1B873593,
        32'h85EBCA6B, 32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1
    };

endpackage

// File: rtl/ibex_bloom_hash.sv
// Multiplicative hash: salts the key, multiplies by the golden ratio constant and
// keeps the top log2(FilterBits) bits of the truncated 32-bit product.
module ibex_bloom_hash
    import ibex_bloom_pkg::*;
#(
    parameter int FilterBits = 1024
) (
    input  logic [31:0]                   k,
    input  logic [2:0]                    i,
    output logic [$clog2(FilterBits)-1:0] index
);

    localparam int IdxW = $clog2(FilterBits);

    logic [31:0] prod;

    assign prod  = (k ^ SALT[i]) * GOLDEN;
    assign index = IdxW'(prod >> (32 - IdxW));

endmodule

// File: rtl/ibex_bloom_unit.sv
// Bloom-filter responder for the EX-stage custom-instruction interface.
//   state | meaning
//   IDLE  | waiting for custom_en_i, latches op and folded key
//   HASH  | one hash index per cycle, read-then-set of the filter bit
//   DONE  | one-cycle valid pulse with result, CLEAR/count update
module ibex_bloom_unit
    import ibex_bloom_pkg::*;
#(
    parameter int FilterBits = 1024,
    parameter int NumHashes  = 3,
    parameter int CountW     = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        custom_en_i,
    input  logic [4:0]  custom_op_i,
    input  logic [31:0] custom_in_RS1_i,
    input  logic [31:0] custom_in_RS2_i,
    output logic        custom_valid_o,
    output logic [31:0] custom_result_o,
    output logic        custom_err_o,
    output logic        custom_busy_o
);

    localparam int         IdxW     = $clog2(FilterBits);
    localparam logic [2:0] LastHash = 3'(NumHashes - 1);

    bloom_state_e          state_q, state_d;
    logic [4:0]            op_q;
    logic [31:0]           key_q;
    logic [2:0]            hash_idx_q;
    logic                  all_set_q;
    logic [FilterBits-1:0] filter_q;
    logic [CountW-1:0]     insert_count;
    logic [IdxW-1:0]       hash_index;

    ibex_bloom_hash #(.FilterBits(FilterBits)) u_hash (
        .k     (key_q),
        .i     (hash_idx_q),
        .index (hash_index)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (custom_en_i) begin
                    if (custom_op_i == OP_INSERT || custom_op_i == OP_CHECK) state_d = ST_HASH;
                    else                                                     state_d = ST_DONE;
                end
            end
            ST_HASH: begin
                if (!custom_en_i)                 state_d = ST_IDLE;
                else if (hash_idx_q == LastHash)  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        custom_valid_o  = 1'b0;
        custom_result_o = '0;
        custom_err_o    = 1'b0;
        custom_busy_o   = (state_q != ST_IDLE);
        if (state_q == ST_DONE) begin
            custom_valid_o = 1'b1;
            case (op_q)
                OP_INSERT, OP_CHECK: custom_result_o = {31'b0, all_set_q};
                OP_CLEAR:            custom_result_o = '0;
                OP_COUNT:            custom_result_o = 32'(insert_count);
                default:             custom_err_o    = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            key_q        <= '0;
            hash_idx_q   <= '0;
            all_set_q    <= 1'b0;
            filter_q     <= '0;
            insert_count <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (custom_en_i) begin
                        op_q       <= custom_op_i;
                        key_q      <= custom_in_RS1_i ^ {custom_in_RS2_i[15:0], custom_in_RS2_i[31:16]};
                        hash_idx_q <= '0;
                        all_set_q  <= 1'b1;
                    end
                end
                ST_HASH: begin
                    // A kill leaves earlier bits set; the filter only ever gains members.
                    if (custom_en_i) begin
                        all_set_q  <= all_set_q & filter_q[hash_index];
                        hash_idx_q <= hash_idx_q + 3'd1;
                        if (op_q == OP_INSERT) filter_q[hash_index] <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (op_q == OP_INSERT && insert_count != '1)
                        insert_count <= insert_count + 1'b1;
                    if (op_q == OP_CLEAR) begin
                        filter_q     <= '0;
                        insert_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ibex_bloom_unit.md
Name: ibex_bloom_unit

Overview:
- Responder side of the EX-stage custom-instruction interface: accepts Bloom-filter ops (insert/check/clear/count) issued by the EX block with RS1/RS2 operands.
- Executes each op over a fixed number of cycles against an internal filter bit-array.
- Returns a one-cycle valid pulse with a 32-bit result that the EX block muxes into result_ex_o.

Parameters:
- FilterBits, 1024, filter array size; power of two, 64..4096.
- NumHashes, 3, hash functions per key, evaluated one per cycle; 1..8.
- CountW, 16, width of the saturating insert counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Synchronous, active-low.
- custom_en_i  in  1  request. Held high by EX until custom_valid_o; deassertion before then is a kill.
- custom_op_i  in  5  opcode; see package.
- custom_in_RS1_i  in  32  key word 0.
- custom_in_RS2_i  in  32  key word 1 (salt).
- custom_valid_o  out  1  one-cycle result pulse.
- custom_result_o  out  32  result; valid only with custom_valid_o, else 0.
- custom_err_o  out  1  unknown opcode; qualified by custom_valid_o.
- custom_busy_o  out  1  high in HASH and DONE.

Behaviour:
- Reset (rst_ni low at posedge):
  - state=IDLE; filter bits all 0; insert_count=0.
  - custom_valid_o=0, custom_result_o=0, custom_err_o=0, custom_busy_o=0.
  - Reset mid-operation abandons the op with no valid pulse.
- States: IDLE, HASH, DONE.
- IDLE:
  - Accept when custom_en_i=1. Register the op and key k = RS1 ^ {RS2[15:0],RS2[31:16]}; clear hash index i and all_set=1.
  - INSERT or CHECK -> HASH. CLEAR, COUNT or unknown op -> DONE.
- HASH, one hash per cycle:
  - Index h_i = ((k ^ SALT[i]) * 32'h9E3779B1) >> (32 - log2(FilterBits)), multiply truncated to 32 bits.
  - all_set &= bit[h_i], using the value before this cycle's write.
  - INSERT sets bit[h_i] this cycle.
  - i increments each cycle; after i = NumHashes-1, go to DONE.
  - If custom_en_i=0 in HASH: go to IDLE, no valid pulse, count unchanged. Bits already set by a partial insert remain set; this is accepted because the filter is monotone.
- DONE:
  - Drive custom_valid_o=1 for one cycle, then go to IDLE. The next request may be accepted in the following cycle.
  - INSERT: result = {31'b0, all_set} (1 = probable duplicate); insert_count increments, saturating at all-ones.
  - CHECK: result = {31'b0, all_set}.
  - CLEAR: all filter bits and insert_count cleared in this cycle; result 0.
  - COUNT: result = zero-extended insert_count.
  - Unknown op: result 0, custom_err_o=1.
- Latency, accept cycle N:
  - INSERT/CHECK: valid at N+NumHashes+1 (N+4 by default).
  - Others: valid at N+1.
- Two hashes of one key hitting the same index is legal. On INSERT the second read sees the bit set by the first.
- custom_en_i is ignored in DONE.

Decomposition:
- Package ibex_bloom_pkg:
  - bloom_op_e: OP_INSERT=5'd1, OP_CHECK=5'd2, OP_CLEAR=5'd3, OP_COUNT=5'd4.
  - bloom_state_e.
  - SALT[8] array: 32'h0, 32'h5BD1E995, 32'hCC9E2D51, 32'h1B873593, 32'h85EBCA6B, 32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1.
  - GOLDEN constant 32'h9E3779B1.
- Sub-module ibex_bloom_hash: combinational; inputs k and i, output index. Reused by the bench's reference model.

Test Plan:
- Empty filter, CHECK RS1=32'h00001234 RS2=0 -> valid exactly at N+4, result 0, err 0; valid high for one cycle only.
- INSERT RS1=32'hDEADBEEF RS2=32'h1 -> result 0; COUNT -> 32'h1. CHECK same key -> result 1. INSERT same key again -> result 1; COUNT -> 32'h2.
- After the inserts, CLEAR -> valid at N+1, result 0. Then COUNT -> 0, and CHECK 32'hDEADBEEF -> 0.
- Op 5'd31 -> valid at N+1, err=1, result 0. Back-to-back CHECK accepted the next cycle completes normally.
- INSERT with custom_en_i dropped in its second HASH cycle -> no valid pulse; COUNT unchanged; busy low next cycle.
- rst_ni low during HASH of an INSERT -> no valid pulse. Afterwards COUNT=0 and CHECK of any prior key returns 0.
- Saturation (bench forces insert_count to all-ones): INSERT -> COUNT still 32'h0000FFFF.
